// File: rtl/eth_tx_frame_fifo_pkg.sv
// Shared AXI-Stream word definitions and write-FSM states for the
// store-and-forward Ethernet TX frame FIFO.
package eth_tx_frame_fifo_pkg;

    localparam int ETH_DATA_W = 64;
    localparam int ETH_KEEP_W = 8;
    localparam int ETH_WORD_W = ETH_DATA_W + ETH_KEEP_W + 1;

    typedef struct packed {
        logic                  last;
        logic [ETH_KEEP_W-1:0] keep;
        logic [ETH_DATA_W-1:0] data;
    } eth_word_t;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_FRAME = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_e;

    function automatic eth_word_t pack_word(input logic                  last,
                                            input logic [ETH_KEEP_W-1:0] keep,
                                            input logic [ETH_DATA_W-1:0] data);
        eth_word_t w;
        w.last = last;
        w.keep = keep;
        w.data = data;
        return w;
    endfunction

endpackage

// File: rtl/eth_tx_frame_fifo_sdp_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Contents are intentionally not reset.
module eth_tx_frame_fifo_sdp_ram
    import eth_tx_frame_fifo_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [ETH_WORD_W-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [ETH_WORD_W-1:0] rd_data
);

    logic [ETH_WORD_W-1:0] mem_q [2**ADDR_W];
    logic [ETH_WORD_W-1:0] rd_data_q;

    // Write port
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward TX frame FIFO: a frame becomes readable only after its
// tlast beat is stored; errored and oversize frames are discarded and counted.
module eth_tx_frame_fifo
    import eth_tx_frame_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int CNT_W      = 32
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [ETH_DATA_W-1:0] s_axis_tdata,
    input  logic [ETH_KEEP_W-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [ETH_DATA_W-1:0] m_axis_tdata,
    output logic [ETH_KEEP_W-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic [CNT_W-1:0]      tx_frames,
    output logic [CNT_W-1:0]      tx_drops
);

    localparam int              PW       = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0]   DEPTH_P  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [PW-1:0]   PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    wr_state_e       state_q, state_d;
    logic            bad_q, bad_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   wr_cur_q, wr_cur_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   fill_q, fill_d;
    logic            rdy_en_q;
    logic            rd_vld_q, rd_vld_d;
    logic            v0_q, v0_d, v1_q, v1_d;
    eth_word_t       ent0_q, ent0_d, ent1_q, ent1_d;
    logic [CNT_W-1:0] frames_q, frames_d, drops_q, drops_d;

    logic            full_s, avail_s, in_drop_s, oversize_s;
    logic            s_ready_s, s_fire_s, m_fire_s;
    logic            ram_we_s, rd_issue_s, drop_inc_s;
    logic [1:0]      occ_s, occ_after_s;
    eth_word_t       ram_wdata_s, ram_rdata_s;

    assign full_s     = (wr_cur_q - rd_ptr_q) == DEPTH_P;
    assign avail_s    = wr_ptr_q != rd_ptr_q;
    assign in_drop_s  = state_q == WR_DROP;
    // A frame that alone fills the buffer can never be committed.
    assign oversize_s = full_s && (wr_ptr_q == rd_ptr_q) && !in_drop_s;
    assign s_ready_s  = rdy_en_q && (!full_s || in_drop_s || oversize_s);
    assign s_fire_s   = s_axis_tvalid && s_ready_s;
    assign m_fire_s   = v0_q && m_axis_tready;
    assign ram_wdata_s = pack_word(s_axis_tlast, s_axis_tkeep, s_axis_tdata);

    eth_tx_frame_fifo_sdp_ram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clock   (clock),
        .wr_en   (ram_we_s),
        .wr_addr (wr_cur_q[DEPTH_LOG2-1:0]),
        .wr_data (ram_wdata_s),
        .rd_en   (rd_issue_s),
        .rd_addr (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_data (ram_rdata_s)
    );

    // Write-control FSM: speculative store, commit on good tlast, rollback or drop otherwise
    always_comb begin
        state_d    = state_q;
        bad_d      = bad_q;
        wr_ptr_d   = wr_ptr_q;
        wr_cur_d   = wr_cur_q;
        ram_we_s   = 1'b0;
        drop_inc_s = 1'b0;
        case (state_q)
            WR_IDLE, WR_FRAME: begin
                if (oversize_s) begin
                    wr_cur_d = wr_ptr_q;
                    if (s_fire_s && s_axis_tlast) begin
                        state_d    = WR_IDLE;
                        bad_d      = 1'b0;
                        drop_inc_s = 1'b1;
                    end else begin
                        state_d = WR_DROP;
                    end
                end else if (s_fire_s) begin
                    ram_we_s = 1'b1;
                    wr_cur_d = wr_cur_q + PTR_ONE;
                    if (s_axis_tlast) begin
                        state_d = WR_IDLE;
                        bad_d   = 1'b0;
                        if (bad_q || s_axis_tuser) begin
                            wr_cur_d   = wr_ptr_q;
                            drop_inc_s = 1'b1;
                        end else begin
                            wr_ptr_d = wr_cur_q + PTR_ONE;
                        end
                    end else begin
                        state_d = WR_FRAME;
                        bad_d   = bad_q | s_axis_tuser;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            WR_DROP: begin
                if (s_fire_s && s_axis_tlast) begin
                    state_d    = WR_IDLE;
                    bad_d      = 1'b0;
                    drop_inc_s = 1'b1;
                end else begin
                    state_d = WR_DROP;
                end
            end
            default: begin
                state_d = WR_IDLE;
            end
        endcase
    end

    // Read prefetch into a 2-entry skid; in-flight RAM reads reserve a skid slot
    always_comb begin
        occ_s       = {1'b0, v0_q} + {1'b0, v1_q} + {1'b0, rd_vld_q};
        occ_after_s = occ_s - {1'b0, m_fire_s};
        rd_issue_s  = avail_s && (occ_after_s < 2'd2);
        rd_ptr_d    = rd_issue_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        rd_vld_d    = rd_issue_s;
        v0_d        = v0_q;
        v1_d        = v1_q;
        ent0_d      = ent0_q;
        ent1_d      = ent1_q;
        if (m_fire_s) begin
            if (v1_q) begin
                ent0_d = ent1_q;
                v0_d   = 1'b1;
                ent1_d = ram_rdata_s;
                v1_d   = rd_vld_q;
            end else begin
                ent0_d = ram_rdata_s;
                v0_d   = rd_vld_q;
                v1_d   = 1'b0;
            end
        end else if (!v0_q) begin
            ent0_d = ram_rdata_s;
            v0_d   = rd_vld_q;
        end else if (!v1_q) begin
            ent1_d = ram_rdata_s;
            v1_d   = rd_vld_q;
        end else begin
            v1_d = v1_q;
        end
    end

    // Frame/drop counters and fill level
    always_comb begin
        frames_d = frames_q + {{(CNT_W-1){1'b0}}, (m_fire_s && ent0_q.last)};
        drops_d  = drops_q + {{(CNT_W-1){1'b0}}, drop_inc_s};
        fill_d   = wr_cur_d - rd_ptr_d;
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= WR_IDLE;
            bad_q    <= 1'b0;
            wr_ptr_q <= {PW{1'b0}};
            wr_cur_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            fill_q   <= {PW{1'b0}};
            rdy_en_q <= 1'b0;
            rd_vld_q <= 1'b0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            ent0_q   <= '0;
            ent1_q   <= '0;
            frames_q <= CNT_ZERO;
            drops_q  <= CNT_ZERO;
        end else begin
            state_q  <= state_d;
            bad_q    <= bad_d;
            wr_ptr_q <= wr_ptr_d;
            wr_cur_q <= wr_cur_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            rdy_en_q <= 1'b1;
            rd_vld_q <= rd_vld_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            frames_q <= frames_d;
            drops_q  <= drops_d;
        end
    end

    assign s_axis_tready = s_ready_s;
    assign m_axis_tdata  = ent0_q.data;
    assign m_axis_tkeep  = ent0_q.keep;
    assign m_axis_tlast  = ent0_q.last;
    assign m_axis_tuser  = 1'b0;
    assign m_axis_tvalid = v0_q;
    assign fill_level    = fill_q;
    assign tx_frames     = frames_q;
    assign tx_drops      = drops_q;

endmodule

// File: tb/tb_eth_tx_frame_fifo.sv
// Directed self-checking bench for eth_tx_frame_fifo (DEPTH_LOG2=9, CNT_W=32).
module tb_eth_tx_frame_fifo;

    logic        clock = 1'b0;
    logic        resetn;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast, s_tuser, s_tvalid, s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast, m_tuser, m_tvalid, m_tready;
    logic [9:0]  fill_level;
    logic [31:0] tx_frames, tx_drops;

    int checks = 0;
    int errors = 0;
    int gap_cnt = 0;
    int s_stalls = 0;
    logic in_frame = 1'b0;
    logic [72:0] out_q[$];
    logic [72:0] exp_q[$];

    always #5 clock = ~clock;

    eth_tx_frame_fifo #(.DEPTH_LOG2(9), .CNT_W(32)) dut (
        .clock(clock), .resetn(resetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .fill_level(fill_level), .tx_frames(tx_frames), .tx_drops(tx_drops)
    );

    // Output collector: records every handshaken beat and any mid-frame tvalid gap
    always @(negedge clock) begin
        if (!resetn) begin
            in_frame <= 1'b0;
        end else begin
            if (in_frame && !m_tvalid) gap_cnt <= gap_cnt + 1;
            if (m_tvalid && m_tready) begin
                out_q.push_back({m_tlast, m_tkeep, m_tdata});
                in_frame <= !m_tlast;
            end
        end
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [72:0] beat_word(input int id, input int i, input int n,
                                              input logic [7:0] lk);
        logic [15:0] a;
        logic [15:0] b;
        a = id[15:0];
        b = i[15:0];
        return {(i == n - 1), ((i == n - 1) ? lk : 8'hFF), a, b, ~a, ~b};
    endfunction

    task automatic drive_beat(input int id, input int i, input int n, input logic user,
                              input logic [7:0] lk);
        logic [72:0] w;
        w = beat_word(id, i, n, lk);
        s_tdata  = w[63:0];
        s_tkeep  = w[71:64];
        s_tlast  = w[72];
        s_tuser  = user;
        s_tvalid = 1'b1;
    endtask

    task automatic send_beat(input int id, input int i, input int n, input logic user,
                             input logic [7:0] lk);
        int   g;
        logic hs;
        g  = 0;
        hs = 1'b0;
        drive_beat(id, i, n, user, lk);
        while (!hs && g < 3000) begin
            @(negedge clock);
            hs = s_tready;
            if (!hs) s_stalls++;
            @(posedge clock);
            #1;
            g++;
        end
        if (!hs) check($sformatf("s_handshake_f%0d_b%0d", id, i), {79'd0, hs}, 80'd1);
    endtask

    task automatic send_frame(input int id, input int n, input int bad_idx,
                              input logic [7:0] lk, input logic expect_out);
        for (int i = 0; i < n; i++) send_beat(id, i, n, (i == bad_idx), lk);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        if (expect_out) begin
            for (int i = 0; i < n; i++) exp_q.push_back(beat_word(id, i, n, lk));
        end
    endtask

    task automatic compare_out(input string tag, input int n);
        int g;
        g = 0;
        while (out_q.size() < n && g < 6000) begin
            @(negedge clock);
            #1;
            g++;
        end
        @(posedge clock);
        #1;
        check({tag, "_count"}, out_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < out_q.size() && i < exp_q.size())
                check($sformatf("%s_beat%0d", tag, i), {7'd0, out_q[i]}, {7'd0, exp_q[i]});
        end
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int          g0, st0, g, beats, idx;
        logic        stall_seen, prev_stall;
        logic [72:0] cur, prev;

        resetn   = 1'b0;
        s_tdata  = 64'd0;
        s_tkeep  = 8'd0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_fill", fill_level, 10'd0);
        check("rst_tx_frames", tx_frames, 32'd0);
        check("rst_tx_drops", tx_drops, 32'd0);
        check("rst_m_tuser", m_tuser, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("rel_s_tready_before_edge", s_tready, 1'b0);
        @(posedge clock);
        #1;
        check("rel_s_tready_after_edge", s_tready, 1'b1);
        g0 = gap_cnt;

        // 1: single 3-beat frame, latency N+3
        m_tready = 1'b1;
        send_frame(1, 3, -1, 8'h0F, 1'b1);
        @(negedge clock);
        check("t1_valid_n1", m_tvalid, 1'b0);
        @(negedge clock);
        check("t1_valid_n2", m_tvalid, 1'b0);
        @(negedge clock);
        check("t1_valid_n3", m_tvalid, 1'b1);
        compare_out("t1", 3);
        check("t1_tx_frames", tx_frames, 32'd1);
        check("t1_fill", fill_level, 10'd0);
        check("t1_gaps", gap_cnt - g0, 32'd0);

        // 2: bad 4-beat frame (tuser on beat 2) then good 2-beat frame
        send_frame(2, 4, 1, 8'hFF, 1'b0);
        send_frame(3, 2, -1, 8'h03, 1'b1);
        compare_out("t2", 2);
        check("t2_tx_drops", tx_drops, 32'd1);
        check("t2_tx_frames", tx_frames, 32'd2);
        check("t2_fill", fill_level, 10'd0);

        // 3: oversize 600-beat frame, then 8-beat frame
        st0 = s_stalls;
        send_frame(4, 600, -1, 8'hFF, 1'b0);
        check("t3_no_stall", s_stalls - st0, 32'd0);
        repeat (10) @(posedge clock);
        #1;
        check("t3_nothing_out", out_q.size(), 32'd0);
        check("t3_tx_drops", tx_drops, 32'd2);
        send_frame(5, 8, -1, 8'h7F, 1'b1);
        compare_out("t3", 8);
        check("t3_tx_frames", tx_frames, 32'd3);
        check("t3_fill", fill_level, 10'd0);

        // 4: back-pressure, 510 committed beats + 4-beat frame, then stall at full
        m_tready = 1'b0;
        for (int f = 0; f < 10; f++) send_frame(10 + f, 51, -1, 8'hFF, 1'b1);
        send_frame(20, 4, -1, 8'h01, 1'b1);
        idx = 0;
        stall_seen = 1'b0;
        drive_beat(21, idx, 8, 1'b0, 8'h3F);
        for (int k = 0; k < 20 && !stall_seen && idx < 7; k++) begin
            @(negedge clock);
            if (!s_tready) stall_seen = 1'b1;
            @(posedge clock);
            #1;
            if (!stall_seen) begin
                idx++;
                drive_beat(21, idx, 8, 1'b0, 8'h3F);
            end
        end
        check("t4_stall_seen", stall_seen, 1'b1);
        check("t4_fill_full", fill_level, 10'd512);
        check("t4_m_valid_held", m_tvalid, 1'b1);
        m_tready = 1'b1;
        for (int i = idx; i < 8; i++) send_beat(21, i, 8, 1'b0, 8'h3F);
        s_tvalid = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(beat_word(21, i, 8, 8'h3F));
        compare_out("t4", 522);
        check("t4_tx_frames", tx_frames, 32'd15);
        check("t4_fill", fill_level, 10'd0);

        // 5: 16-beat frame with m_tready toggling every cycle
        m_tready = 1'b0;
        send_frame(30, 16, -1, 8'hFF, 1'b1);
        g = 0;
        while (!m_tvalid && g < 20) begin
            @(negedge clock);
            g++;
        end
        check("t5_first_valid", m_tvalid, 1'b1);
        beats = 0;
        prev_stall = 1'b0;
        prev = 73'd0;
        g = 0;
        while (beats < 16 && g < 100) begin
            @(posedge clock);
            #1;
            m_tready = !m_tready;
            @(negedge clock);
            cur = {m_tlast, m_tkeep, m_tdata};
            check($sformatf("t5_valid_c%0d", g), m_tvalid, 1'b1);
            if (prev_stall) check($sformatf("t5_hold_c%0d", g), {7'd0, cur}, {7'd0, prev});
            if (m_tvalid && m_tready) beats++;
            prev_stall = m_tvalid && !m_tready;
            prev = cur;
            g++;
        end
        check("t5_beats", beats, 32'd16);
        @(posedge clock);
        #1;
        m_tready = 1'b1;
        compare_out("t5", 16);
        check("t5_tx_frames", tx_frames, 32'd16);

        // 6: reset with a frame half-delivered and another half-received
        m_tready = 1'b0;
        send_frame(40, 10, -1, 8'hFF, 1'b0);
        for (int i = 0; i < 5; i++) send_beat(41, i, 10, 1'b0, 8'hFF);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        beats = 0;
        g = 0;
        while (beats < 5 && g < 50) begin
            @(negedge clock);
            if (m_tvalid && m_tready) beats++;
            g++;
        end
        check("t6_beats_before_reset", beats, 32'd5);
        @(posedge clock);
        #1;
        m_tready = 1'b0;
        resetn = 1'b0;
        #1;
        check("t6_rst_m_tvalid", m_tvalid, 1'b0);
        check("t6_rst_s_tready", s_tready, 1'b0);
        check("t6_rst_fill", fill_level, 10'd0);
        check("t6_rst_tx_frames", tx_frames, 32'd0);
        check("t6_rst_tx_drops", tx_drops, 32'd0);
        out_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check("t6_rel_s_tready", s_tready, 1'b1);
        m_tready = 1'b1;
        send_frame(42, 2, -1, 8'h0F, 1'b1);
        compare_out("t6", 2);
        check("t6_tx_frames", tx_frames, 32'd1);
        check("t6_tx_drops", tx_drops, 32'd0);
        check("t6_fill", fill_level, 10'd0);
        check("all_gaps", gap_cnt - g0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
